// File: rtl/draw_rect_ctl.sv
// Motion controller for the draggable rectangle: tracks the mouse while idle, then
// falls under per-frame gravity, bounces off the floor with damping, and rests.
module draw_rect_ctl #(
    parameter int RECT_H   = 64,
    parameter int SCREEN_H = 768,
    parameter int GRAVITY  = 1,
    parameter int V_MIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy
);

    localparam int                 FLOOR     = SCREEN_H - RECT_H;
    localparam logic        [11:0] FLOOR_U   = 12'(FLOOR);
    localparam logic signed [12:0] FLOOR_S   = 13'(FLOOR);
    localparam logic signed [12:0] GRAVITY_S = 13'(GRAVITY);
    localparam logic signed [12:0] V_MIN_S   = 13'(V_MIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FALL,
        ST_LANDED
    } state_t;

    state_t             state_q;
    logic        [11:0] xpos_q;
    logic        [11:0] ypos_q;
    logic signed [11:0] v_q;
    logic               busy_q;
    logic               vblnk_dly_q;
    logic               left_dly_q;

    logic               tick;
    logic               click;
    logic        [11:0] track_y;
    logic signed [12:0] vn;
    logic signed [12:0] yn;
    logic signed [12:0] r;
    logic               floor_hit;
    logic               ceil_hit;
    logic               settle;

    // Both edge detectors compare against last cycle's level, so a held input never re-fires.
    assign tick    = vblnk & ~vblnk_dly_q;
    assign click   = mouse_left & ~left_dly_q;
    assign track_y = (mouse_ypos > FLOOR_U) ? FLOOR_U : mouse_ypos;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        vn        = {v_q[11], v_q} + GRAVITY_S;
        yn        = {1'b0, ypos_q} + vn;
        r         = vn - (vn >>> 2);
        floor_hit = (yn >= FLOOR_S);
        ceil_hit  = (yn < 13'sd0);
        settle    = (r < V_MIN_S);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            xpos_q      <= '0;
            ypos_q      <= '0;
            v_q         <= '0;
            busy_q      <= 1'b0;
            vblnk_dly_q <= 1'b0;
            left_dly_q  <= 1'b0;
        end else begin
            vblnk_dly_q <= vblnk;
            left_dly_q  <= mouse_left;
            case (state_q)
                ST_IDLE: begin
                    xpos_q <= mouse_xpos;
                    ypos_q <= track_y;
                    if (click) begin
                        v_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        if (floor_hit) begin
                            ypos_q <= FLOOR_U;
                            if (settle) begin
                                v_q     <= '0;
                                busy_q  <= 1'b0;
                                state_q <= ST_LANDED;
                            end else begin
                                v_q <= -r[11:0];
                            end
                        end else if (ceil_hit) begin
                            ypos_q <= '0;
                            v_q    <= '0;
                        end else begin
                            ypos_q <= yn[11:0];
                            v_q    <= vn[11:0];
                        end
                    end
                end
                ST_LANDED: begin
                    if (click) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_draw_rect_ctl;

    localparam int FLOOR    = 704;
    localparam int M_IDLE   = 0;
    localparam int M_FALL   = 1;
    localparam int M_LANDED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        mouse_left = 1'b0;
    logic        vblnk = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    draw_rect_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vblnk      (vblnk),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position, velocity and mode as plain integers.
    int m_x, m_y, m_v, m_mode;
    bit m_pv, m_pl;
    bit cmp_en = 1'b0;

    always @(posedge clk) begin : model
        int vn, yn, r;
        bit tk, ck;
        if (rst) begin
            m_x = 0; m_y = 0; m_v = 0; m_mode = M_IDLE;
            m_pv = 0; m_pl = 0;
            cmp_en = 1'b1;
        end else begin
            tk   = vblnk && !m_pv;
            ck   = mouse_left && !m_pl;
            m_pv = vblnk;
            m_pl = mouse_left;
            if (m_mode == M_IDLE) begin
                m_x = int'(mouse_xpos);
                m_y = (int'(mouse_ypos) > FLOOR) ? FLOOR : int'(mouse_ypos);
                if (ck) begin
                    m_v    = 0;
                    m_mode = M_FALL;
                end
            end else if (m_mode == M_FALL) begin
                if (tk) begin
                    vn = m_v + 1;
                    yn = m_y + vn;
                    if (yn >= FLOOR) begin
                        m_y = FLOOR;
                        r   = vn - (vn >>> 2);
                        if (r < 2) begin
                            m_v    = 0;
                            m_mode = M_LANDED;
                        end else begin
                            m_v = -r;
                        end
                    end else if (yn < 0) begin
                        m_y = 0;
                        m_v = 0;
                    end else begin
                        m_y = yn;
                        m_v = vn;
                    end
                end
            end else if (ck) begin
                m_mode = M_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("xpos", xpos, m_x);
            check("ypos", ypos, m_y);
            check("busy", busy, m_mode == M_FALL);
        end
    end

    task automatic tick_once();
        @(negedge clk) vblnk = 1'b1;
        @(negedge clk) vblnk = 1'b0;
    endtask

    task automatic click_once();
        @(negedge clk) mouse_left = 1'b1;
        @(negedge clk) mouse_left = 1'b0;
    endtask

    int damp_exp[11] = '{701, 703, 704, 702, 701, 701, 702, 704, 703, 703, 704};

    initial begin
        // Reset and tracking
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd200;
        repeat (3) @(negedge clk);
        check("rst_x", xpos, 0);
        check("rst_y", ypos, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("track_x", xpos, 100);
        check("track_y", ypos, 200);
        mouse_ypos = 12'd760;
        @(negedge clk);
        check("track_clamp", ypos, 704);

        // Free fall from the top of the screen
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd0;
        @(negedge clk);
        click_once();
        check("ff_start_y", ypos, 0);
        check("ff_start_busy", busy, 1);
        for (int n = 1; n <= 38; n++) begin
            mouse_xpos = 12'($urandom_range(0, 4095));
            mouse_ypos = 12'($urandom_range(0, 4095));
            tick_once();
            check("ff_x", xpos, 300);
            if (n < 38) check("ff_y", ypos, n * (n + 1) / 2);
            if (n == 37) check("ff_t37", ypos, 703);
            if (n == 10) begin
                click_once();
                check("fall_click_busy", busy, 1);
                check("fall_click_y", ypos, 55);
            end
        end
        check("ff_t38_y", ypos, 704);
        check("ff_t38_v", $signed(dut.v_q), -29);
        for (int k = 0; k < 400 && busy; k++) tick_once();
        check("ff_landed", busy, 0);
        check("ff_landed_y", ypos, 704);

        // Click in LANDED with the button then held
        @(negedge clk);
        mouse_left = 1'b1;
        mouse_xpos = 12'd55;
        mouse_ypos = 12'd66;
        @(negedge clk);
        check("landed_click_hold_y", ypos, 704);
        @(negedge clk);
        check("resume_x", xpos, 55);
        check("resume_y", ypos, 66);
        repeat (3) tick_once();
        check("held_no_retrigger", busy, 0);
        @(negedge clk) mouse_left = 1'b0;

        // Damped landing from y = 700
        mouse_xpos = 12'd123;
        mouse_ypos = 12'd700;
        @(negedge clk);
        click_once();
        for (int i = 0; i < 11; i++) begin
            tick_once();
            check("damp_y", ypos, damp_exp[i]);
        end
        check("damp_busy", busy, 0);
        tick_once();
        check("landed_hold_y", ypos, 704);
        click_once();

        // Click and tick in the same IDLE cycle
        mouse_xpos = 12'd7;
        mouse_ypos = 12'd10;
        @(negedge clk);
        @(negedge clk);
        vblnk = 1'b1;
        mouse_left = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
        mouse_left = 1'b0;
        check("simul_y", ypos, 10);
        check("simul_busy", busy, 1);
        tick_once();
        check("simul_next_y", ypos, 11);

        // Reset in the middle of a fall
        repeat (19) tick_once();
        @(negedge clk);
        vblnk = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
        check("midrst_x", xpos, 0);
        check("midrst_y", ypos, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd500;
        @(negedge clk);
        check("midrst_track_x", xpos, 400);
        check("midrst_track_y", ypos, 500);

        // Randomized traffic checked by the model
        repeat (4000) begin
            @(negedge clk);
            vblnk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) mouse_left = ~mouse_left;
            mouse_xpos = 12'($urandom_range(0, 4095));
            mouse_ypos = 12'($urandom_range(0, 4095));
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_rect_ctl.md
# draw_rect_ctl

Motion controller for the draggable rectangle on the 1024x768 display. It tracks the mouse position while idle. A left click releases the rectangle, and it then falls under per-frame gravity, bounces off the screen floor with damping, and comes to rest. Its `xpos`/`ypos` outputs feed the rectangle-drawing stage, which sits directly ahead of the mouse-cursor overlay in the `vga_if` pixel chain. All logic runs in the 65 MHz pixel clock domain. The mouse inputs are already synchronised to `clk`.

## Interface
Parameters:
- `RECT_H`, default 64: rectangle height in pixels.
- `SCREEN_H`, default 768: visible lines.
- `GRAVITY`, default 1: velocity increment per frame, in px/frame.
- `V_MIN`, default 2: minimum rebound speed; anything slower lands.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `mouse_xpos`, in, 12: mouse X, unsigned.
- `mouse_ypos`, in, 12: mouse Y, unsigned.
- `mouse_left`, in, 1: left button level, 1 = pressed.
- `vblnk`, in, 1: vertical blank from the timing generator.
- `xpos`, out, 12: rectangle top-left X.
- `ypos`, out, 12: rectangle top-left Y.
- `busy`, out, 1: 1 while in FALL.

## Operation
- Derived constant: `FLOOR = SCREEN_H - RECT_H`, which is 704 with the defaults.
- Internal registers:
  - `vblnk_d` and `left_d`, used for edge detection.
  - `v`: signed 12-bit velocity, positive = downward.
  - `state`.
- Derived pulses:
  - `tick` = `vblnk & ~vblnk_d`, one cycle per frame.
  - `click` = `mouse_left & ~left_d`.
- IDLE:
  - Every cycle, `xpos <= mouse_xpos` and `ypos <= min(mouse_ypos, FLOOR)`.
  - On `click`: `v <= 0`, go to FALL. `xpos`/`ypos` take the current mouse values (clamped) in that same cycle.
- FALL:
  - `xpos` is frozen and clicks are ignored.
  - On `tick`: `vn = v + GRAVITY`, `yn = ypos + vn`, with signed 13-bit arithmetic.
    - If `yn >= FLOOR`: `ypos <= FLOOR`, `r = vn - (vn >>> 2)`.
      - If `r < V_MIN`: `v <= 0`, go to LANDED.
      - Else: `v <= -r`.
    - Else if `yn < 0`: `ypos <= 0`, `v <= 0`.
    - Else: `ypos <= yn`, `v <= vn`.
- LANDED:
  - `xpos`/`ypos` hold.
  - On `click`: go to IDLE. Mouse tracking resumes on the next cycle.
- Simultaneous events:
  - `click` and `tick` in the same cycle in IDLE: enter FALL, and no physics step is taken for that tick.
  - `click` during FALL: no effect.
  - A held button never re-triggers; only a 0→1 edge counts.
- Reset at any time, including mid-FALL, returns to IDLE on the next edge.

## Timing
- Reset values:
  - `xpos = 0`, `ypos = 0`, `busy = 0`.
  - `v = 0`, `vblnk_d = 0`, `left_d = 0`, state IDLE.
- In IDLE, the outputs are registered, giving 1-cycle latency from the mouse inputs.
- A physics update appears on `xpos`/`ypos` 1 cycle after the `vblnk` rising edge, i.e. during blanking. Position is therefore never changed mid-frame.
- `busy` is registered:
  - It rises 1 cycle after the `click` edge that enters FALL.
  - It falls in the same cycle that `ypos` is written with the landing value.
- Edge detectors are registered, so the first cycle after reset cannot produce a `tick` or `click` even if the inputs are high. This follows from the reset values of 0.

## Test plan
- **Reset/track.** Assert `rst` 3 cycles, then release with mouse at (100, 200). Required: outputs are (0, 0) during reset, then `xpos = 100` and `ypos = 200` one cycle after release. With `mouse_ypos = 760`, `ypos = 704`.
- **Free fall.** Click with mouse at (300, 0), then apply vblnk edges. Required:
  - After tick n, `ypos = n(n+1)/2`; tick 37 gives `ypos = 703`.
  - Tick 38 gives `ypos = 704` and `v = -29`, with `xpos = 300` throughout.
- **Damped landing.** Click at y = 700. Required `ypos` after ticks 1..11: 701, 703, 704, 702, 701, 701, 702, 704, 703, 703, 704. After tick 11: LANDED and `busy = 0`.
- **Clicks.**
  - A click during FALL has no effect.
  - A held button generates only one `click`.
  - A click in LANDED returns to IDLE, and `xpos`/`ypos` follow the mouse the next cycle.
- **Simultaneous click + tick in IDLE** with mouse at y = 10. Required: FALL is entered, `ypos = 10` (no step on that tick), and the next tick gives `ypos = 11`.
- **Reset mid-fall.** Assert `rst` at tick 20. Required: outputs become 0, state is IDLE, and tracking resumes after release.
